// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, bit-time counter width and the
// 100 MHz bit-time counts behind the Baud_Decode select codes.
package uart_pkg;

  localparam int CNT_W = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // Bit-time counts at 100 MHz, indexed by the Baud_Decode select code
  localparam logic [CNT_W-1:0] BAUD_300    = 19'd333333;
  localparam logic [CNT_W-1:0] BAUD_1200   = 19'd83333;
  localparam logic [CNT_W-1:0] BAUD_2400   = 19'd41667;
  localparam logic [CNT_W-1:0] BAUD_4800   = 19'd20833;
  localparam logic [CNT_W-1:0] BAUD_9600   = 19'd10417;
  localparam logic [CNT_W-1:0] BAUD_19200  = 19'd5208;
  localparam logic [CNT_W-1:0] BAUD_38400  = 19'd2604;
  localparam logic [CNT_W-1:0] BAUD_57600  = 19'd1736;
  localparam logic [CNT_W-1:0] BAUD_115200 = 19'd868;
  localparam logic [CNT_W-1:0] BAUD_230400 = 19'd434;
  localparam logic [CNT_W-1:0] BAUD_460800 = 19'd217;
  localparam logic [CNT_W-1:0] BAUD_921600 = 19'd109;

  function automatic logic [CNT_W-1:0] baud_select(input logic [3:0] sel);
    logic [CNT_W-1:0] cnt;
    case (sel)
      4'd0:    cnt = BAUD_300;
      4'd1:    cnt = BAUD_1200;
      4'd2:    cnt = BAUD_2400;
      4'd3:    cnt = BAUD_4800;
      4'd4:    cnt = BAUD_9600;
      4'd5:    cnt = BAUD_19200;
      4'd6:    cnt = BAUD_38400;
      4'd7:    cnt = BAUD_57600;
      4'd8:    cnt = BAUD_115200;
      4'd9:    cnt = BAUD_230400;
      4'd10:   cnt = BAUD_460800;
      4'd11:   cnt = BAUD_921600;
      default: cnt = '0;
    endcase
    return cnt;
  endfunction

  // Wire bits after the start bit, excluding stop: data (7 or 8) plus optional parity
  function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
    return 4'd7 + {3'd0, eight} + {3'd0, pen};
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable bit-time down-counter shared by the UART engines.
// expire flags the cycle on which the count steps from 1 to 0 (or rests at 0).
module uart_bit_timer #(
  parameter int W = uart_pkg::CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  import uart_pkg::*;

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  // Firing at 1 rather than 0 makes a load of N span exactly N cycles
  assign expire = (count[W-1:1] == '0);

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: synchronizes rx, samples mid-bit frames timed by a latched
// bit-time count, and presents the byte with ready, parity, framing and overrun flags.
//
// state | meaning
// IDLE  | waiting for a low rx with a nonzero baud_count
// START | half a bit time in; confirm the start bit is still low
// DATA  | sampling data and parity bits every bit time
// STOP  | sample the stop bit, then load outputs on the following cycle
module uart_rx_engine #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = uart_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             rx,
  input  logic [CNT_W-1:0] baud_count,
  input  logic             eight,
  input  logic             pen,
  input  logic             ohel,
  input  logic             rx_read,
  output logic [7:0]       rx_data,
  output logic             rxrdy,
  output logic             perr,
  output logic             ferr,
  output logic             ovf
);
  import uart_pkg::*;

  logic [SYNC_STAGES-1:0] sync;
  logic                   rx_s;

  rx_state_t              state;
  rx_state_t              state_nxt;

  logic [CNT_W-1:0]       bt;
  logic                   eight_l;
  logic                   pen_l;
  logic                   ohel_l;
  logic [3:0]             n_bits;
  logic [3:0]             bit_cnt;
  logic [9:0]             shreg;
  logic                   stop_bit;
  logic                   stop_done;

  logic                   tmr_load;
  logic [CNT_W-1:0]       tmr_val;
  logic                   tmr_expire;

  logic                   start_en;
  logic                   shift_en;
  logic                   stop_en;
  logic                   frame_load;

  logic [8:0]             aligned;
  logic [7:0]             data_w;
  logic                   par_w;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync[SYNC_STAGES-1];

  uart_bit_timer #(
    .W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

  assign n_bits = frame_bits(eight_l, pen_l);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!rx_s && baud_count != '0) state_nxt = START;
      end
      START: begin
        if (tmr_expire) state_nxt = rx_s ? IDLE : DATA;
      end
      DATA: begin
        if (tmr_expire && bit_cnt == n_bits - 4'd1) state_nxt = STOP;
      end
      STOP: begin
        if (stop_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tmr_load   = 1'b0;
    tmr_val    = '0;
    start_en   = 1'b0;
    shift_en   = 1'b0;
    stop_en    = 1'b0;
    frame_load = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s && baud_count != '0) begin
          start_en = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = baud_count >> 1;
        end
      end
      START: begin
        if (tmr_expire && !rx_s) begin
          tmr_load = 1'b1;
          tmr_val  = bt;
        end
      end
      DATA: begin
        if (tmr_expire) begin
          shift_en = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = bt;
        end
      end
      STOP: begin
        if (stop_done) begin
          frame_load = 1'b1;
        end else if (tmr_expire) begin
          stop_en = 1'b1;
        end
      end
      default: begin
        tmr_load = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bt        <= '0;
      eight_l   <= 1'b0;
      pen_l     <= 1'b0;
      ohel_l    <= 1'b0;
      bit_cnt   <= '0;
      shreg     <= '0;
      stop_bit  <= 1'b0;
      stop_done <= 1'b0;
    end else begin
      if (start_en) begin
        bt      <= baud_count;
        eight_l <= eight;
        pen_l   <= pen;
        ohel_l  <= ohel;
        bit_cnt <= '0;
      end
      if (shift_en) begin
        shreg   <= {rx_s, shreg[9:1]};
        bit_cnt <= bit_cnt + 4'd1;
      end
      if (stop_en) begin
        stop_bit  <= rx_s;
        stop_done <= 1'b1;
      end
      if (frame_load) begin
        stop_done <= 1'b0;
      end
    end
  end

  // Bits enter at the MSB, so a short frame sits high in the register
  assign aligned = 9'(shreg >> (4'd10 - n_bits));
  assign data_w  = eight_l ? aligned[7:0] : {1'b0, aligned[6:0]};
  assign par_w   = eight_l ? aligned[8] : aligned[7];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_data <= '0;
      rxrdy   <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else if (frame_load) begin
      rx_data <= data_w;
      perr    <= pen_l & (^data_w ^ par_w ^ ohel_l);
      ferr    <= ~stop_bit;
      ovf     <= rxrdy;
      rxrdy   <= 1'b1;
    end else if (rx_read) begin
      rxrdy <= 1'b0;
      ovf   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Randomized scoreboard bench for uart_rx_engine: a frame driver pushes expected
// results, a negedge monitor pops and compares whenever a frame is presented.
module tb_uart_rx_engine;

  localparam int S = 2;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        rx         = 1'b1;
  logic [18:0] baud_count = '0;
  logic        eight      = 1'b1;
  logic        pen        = 1'b0;
  logic        ohel       = 1'b0;
  logic        rx_read    = 1'b0;
  logic [7:0]  rx_data;
  logic        rxrdy;
  logic        perr;
  logic        ferr;
  logic        ovf;

  uart_rx_engine #(
    .SYNC_STAGES (S),
    .CNT_W       (19)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .baud_count (baud_count),
    .eight      (eight),
    .pen        (pen),
    .ohel       (ohel),
    .rx_read    (rx_read),
    .rx_data    (rx_data),
    .rxrdy      (rxrdy),
    .perr       (perr),
    .ferr       (ferr),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovf;
    int         t_fall;
    int         lat;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;

  int n_vec = 0;
  int n_err = 0;

  // Expected steady-state outputs after every issued event
  logic [7:0] m_data  = '0;
  logic       m_rxrdy = 1'b0;
  logic       m_perr  = 1'b0;
  logic       m_ferr  = 1'b0;
  logic       m_ovf   = 1'b0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_static(input string tag);
    cmp({tag, "_rxrdy"},   32'(rxrdy),   32'(m_rxrdy));
    cmp({tag, "_rx_data"}, 32'(rx_data), 32'(m_data));
    cmp({tag, "_perr"},    32'(perr),    32'(m_perr));
    cmp({tag, "_ferr"},    32'(ferr),    32'(m_ferr));
    cmp({tag, "_ovf"},     32'(ovf),     32'(m_ovf));
  endtask

  function automatic int frame_latency(input int bt, input logic e8, input logic pe);
    int n;
    n = 7 + int'(e8) + int'(pe);
    return (bt / 2) + (n + 1) * bt + S + 2;
  endfunction

  // Drive one frame with the current configuration; parity is correct unless pflip
  task automatic send_frame(input logic [7:0] d, input logic stp, input logic pflip);
    int         bt;
    int         nd;
    int         ones;
    logic [7:0] dm;
    logic       par;
    exp_t       e;
    bt   = int'(baud_count);
    nd   = eight ? 8 : 7;
    dm   = eight ? d : {1'b0, d[6:0]};
    ones = $countones(dm);
    par  = (ohel ? ((ones % 2) == 0) : ((ones % 2) == 1)) ^ pflip;
    @(negedge clk);
    rx       = 1'b0;
    e.data   = dm;
    e.perr   = pen && (((ones + int'(par)) % 2) != (ohel ? 1 : 0));
    e.ferr   = !stp;
    e.ovf    = m_rxrdy;
    e.t_fall = cyc;
    e.lat    = frame_latency(bt, eight, pen);
    sbq.push_back(e);
    m_data  = e.data;
    m_perr  = e.perr;
    m_ferr  = e.ferr;
    m_ovf   = e.ovf;
    m_rxrdy = 1'b1;
    repeat (bt) @(negedge clk);
    for (int i = 0; i < nd; i++) begin
      rx = dm[i];
      repeat (bt) @(negedge clk);
    end
    if (pen) begin
      rx = par;
      repeat (bt) @(negedge clk);
    end
    rx = stp;
    repeat (bt) @(negedge clk);
    rx = 1'b1;
    if (!stp) repeat (bt) @(negedge clk);
  endtask

  task automatic do_read();
    @(negedge clk);
    rx_read = 1'b1;
    @(negedge clk);
    rx_read = 1'b0;
    m_rxrdy = 1'b0;
    m_ovf   = 1'b0;
  endtask

  logic p_rxrdy = 1'b0;
  logic p_ovf   = 1'b0;

  always @(negedge clk) begin
    if ((rxrdy && !p_rxrdy) || (ovf && !p_ovf)) begin
      if (sbq.size() == 0) begin
        cmp("unexpected_frame_queue_depth", 32'(sbq.size()), 32'd1);
      end else begin
        mon_e = sbq.pop_front();
        cmp("frame_rx_data", 32'(rx_data), 32'(mon_e.data));
        cmp("frame_rxrdy",   32'(rxrdy),   32'd1);
        cmp("frame_perr",    32'(perr),    32'(mon_e.perr));
        cmp("frame_ferr",    32'(ferr),    32'(mon_e.ferr));
        cmp("frame_ovf",     32'(ovf),     32'(mon_e.ovf));
        cmp("frame_latency", 32'(cyc - mon_e.t_fall), 32'(mon_e.lat));
      end
    end
    p_rxrdy = rxrdy;
    p_ovf   = ovf;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat_b;

    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check_static("reset");

    // Disabled baud: a low rx must not start a frame
    rx = 1'b0;
    repeat (60) @(negedge clk);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_static("baud_zero");

    // 8N1 at 115200
    baud_count = 19'd868;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    send_frame(8'h55, 1'b1, 1'b0);
    check_static("8n1");
    do_read();
    check_static("8n1_read");

    // 7E1 then 7O1 with a zero parity bit
    baud_count = 19'd434;
    eight = 1'b0; pen = 1'b1; ohel = 1'b0;
    send_frame(8'h41, 1'b1, 1'b0);
    check_static("7e1");
    do_read();
    ohel = 1'b1;
    send_frame(8'h41, 1'b1, 1'b1);
    check_static("7o1");
    do_read();

    // Framing error
    baud_count = 19'd217;
    eight = 1'b1; pen = 1'b0; ohel = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0);
    check_static("ferr");
    do_read();

    // Start-bit glitch shorter than half a bit
    baud_count = 19'd868;
    @(negedge clk);
    rx = 1'b0;
    repeat (300) @(negedge clk);
    rx = 1'b1;
    repeat (1200) @(negedge clk);
    check_static("glitch");

    // Overrun: two frames without a read
    baud_count = 19'd217;
    send_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'hED, 1'b1, 1'b0);
    check_static("overrun");
    do_read();
    check_static("overrun_read");

    // Read pulse landing on the load cycle of a second frame
    send_frame(8'h3A, 1'b1, 1'b0);
    lat_b = frame_latency(217, 1'b1, 1'b0);
    fork
      send_frame(8'hC7, 1'b1, 1'b0);
      begin
        @(negedge clk);
        repeat (lat_b - 1) @(negedge clk);
        rx_read = 1'b1;
        @(negedge clk);
        rx_read = 1'b0;
      end
    join
    check_static("read_on_load");
    do_read();

    // Reset during data bit 3, with flags set beforehand
    send_frame(8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rx = 1'b0;
    repeat (217) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = i[0];
      repeat (217) @(negedge clk);
    end
    rx = 1'b0;
    repeat (108) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    m_data = '0; m_rxrdy = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovf = 1'b0;
    check_static("reset_mid_frame");
    reset_n = 1'b1;
    rx = 1'b1;
    repeat (217 * 12) @(negedge clk);
    check_static("after_reset_idle");
    send_frame(8'h3C, 1'b1, 1'b0);
    check_static("after_reset_frame");
    do_read();

    // Randomized frames
    for (int k = 0; k < 24; k++) begin
      baud_count = 19'($urandom_range(16, 120));
      eight      = 1'($urandom_range(0, 1));
      pen        = 1'($urandom_range(0, 1));
      ohel       = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(8'($urandom), ($urandom_range(0, 5) != 0), 1'($urandom_range(0, 1)));
      if (m_ovf || ($urandom_range(0, 2) != 0)) do_read();
    end
    check_static("random_end");

    for (int w = 0; w < 2000 && sbq.size() != 0; w++) @(negedge clk);
    cmp("scoreboard_drained", 32'(sbq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
